// File: rtl/sync_counter_n.sv
// sync_counter_n
// Parametrised synchronous up/down counter with modulus MODULO.
// Q and CO are registered; TC is a combinational look-ahead of the next wrap
// and is the enable for the next-higher stage when counters are cascaded.
// Priority on each rising edge: CLR > LOAD > EN (UP selects direction).

module sync_counter_n #(
  parameter int WIDTH       = 4,
  parameter int MODULO      = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality. An illegal combination stops the
  // build; there is no runtime handling of out-of-range configurations.
  // ---------------------------------------------------------------------------
  localparam longint unsigned SPAN = 64'd1 << WIDTH;

  if (WIDTH < 32'sd1) begin : g_bad_width
    $error("sync_counter_n: WIDTH must be at least 1");
  end

  if ((MODULO < 32'sd2) || (64'(MODULO) > SPAN)) begin : g_bad_modulo
    $error("sync_counter_n: MODULO must lie in 2 .. 2**WIDTH");
  end

  if ((RESET_VALUE < 32'sd0) || (RESET_VALUE >= MODULO)) begin : g_bad_reset
    $error("sync_counter_n: RESET_VALUE must be below MODULO");
  end

  // ---------------------------------------------------------------------------
  // Constants. MOD_EXT is one bit wider than the counter so that a full-range
  // modulus (2**WIDTH) is representable without truncation.
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO_Q   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);

  // ---------------------------------------------------------------------------
  // Helper: load value with saturating clamp. Anything at or above the
  // modulus is pinned to the top legal count so Q can never leave range.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] d_ext;
    d_ext = {1'b0, d};
    if (d_ext < MOD_EXT) begin
      clamp_load = d;
    end else begin
      clamp_load = MAX_Q;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] q_r;
  logic             co_r;

  logic [WIDTH-1:0] q_next_s;
  logic             co_next_s;

  logic [WIDTH:0]   up_sum_s;    // q + 1 at WIDTH+1 bits
  logic [WIDTH:0]   dn_diff_s;   // q - 1 at WIDTH+1 bits, MSB is the borrow
  logic             up_wrap_s;
  logic             dn_wrap_s;
  logic [WIDTH-1:0] up_val_s;
  logic [WIDTH-1:0] dn_val_s;
  logic [WIDTH-1:0] load_val_s;
  logic             at_max_s;
  logic             at_zero_s;

  // Extended-width increment/decrement and their wrap conditions.
  always_comb begin
    up_sum_s  = {1'b0, q_r} + ONE_EXT;
    dn_diff_s = {1'b0, q_r} - ONE_EXT;
    // q never exceeds MODULO-1, so reaching MOD_EXT is exactly the up wrap,
    // and a borrow out of the extended subtract is exactly the down wrap.
    up_wrap_s = (up_sum_s == MOD_EXT);
    dn_wrap_s = dn_diff_s[WIDTH];
    if (up_wrap_s) begin
      up_val_s = ZERO_Q;
    end else begin
      up_val_s = up_sum_s[WIDTH-1:0];
    end
    if (dn_wrap_s) begin
      dn_val_s = MAX_Q;
    end else begin
      dn_val_s = dn_diff_s[WIDTH-1:0];
    end
    load_val_s = clamp_load(D);
  end

  // Terminal-count detection on the registered count (WIDTH-bit compares).
  always_comb begin
    at_max_s  = (q_r == MAX_Q);
    at_zero_s = (q_r == ZERO_Q);
  end

  // Next-state selection with strict priority CLR > LOAD > EN.
  always_comb begin
    q_next_s  = q_r;
    co_next_s = 1'b0;
    if (CLR) begin
      q_next_s  = ZERO_Q;
      co_next_s = 1'b0;
    end else if (LOAD) begin
      q_next_s  = load_val_s;
      co_next_s = 1'b0;
    end else if (EN) begin
      case (UP)
        1'b1: begin
          q_next_s  = up_val_s;
          co_next_s = up_wrap_s;
        end
        1'b0: begin
          q_next_s  = dn_val_s;
          co_next_s = dn_wrap_s;
        end
        default: begin
          q_next_s  = q_r;
          co_next_s = 1'b0;
        end
      endcase
    end else begin
      q_next_s  = q_r;
      co_next_s = 1'b0;
    end
  end

  // Count and wrap-pulse registers; RST forces them asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r  <= RST_Q;
      co_r <= 1'b0;
    end else begin
      q_r  <= q_next_s;
      co_r <= co_next_s;
    end
  end

  // Look-ahead terminal count: high in the cycle before a wrapping edge.
  always_comb begin
    if (UP) begin
      TC = EN & at_max_s;
    end else begin
      TC = EN & at_zero_s;
    end
  end

  assign Q  = q_r;
  assign CO = co_r;

endmodule

// File: tb/tb_sync_counter_n.sv
// Self-checking bench for sync_counter_n: directed scenarios from the test
// plan plus randomized stimulus against an arithmetic reference model.

module tb_sync_counter_n;

  logic clk;

  // Instance A: WIDTH=4, MODULO=16, RESET_VALUE=10
  logic       a_rst, a_clr, a_load, a_en, a_up;
  logic [3:0] a_d, a_q;
  logic       a_tc, a_co;

  // Instance B: WIDTH=4, MODULO=10, RESET_VALUE=0
  logic       b_rst, b_clr, b_load, b_en, b_up;
  logic [3:0] b_d, b_q;
  logic       b_tc, b_co;

  // Cascade C: two WIDTH=4, MODULO=16 stages
  logic       c_rst, c_clr, c_load, c_en, c_up;
  logic [3:0] c_d_lo, c_d_hi, c_q_lo, c_q_hi;
  logic       c_tc_lo, c_tc_hi, c_co_lo, c_co_hi;

  int n_checks;
  int n_errors;

  // Reference model state for instance B
  localparam int MB = 10;
  int   mb_q;
  logic mb_co;

  sync_counter_n #(.WIDTH(4), .MODULO(16), .RESET_VALUE(10)) dut_a (
    .CLK(clk), .RST(a_rst), .CLR(a_clr), .LOAD(a_load), .D(a_d),
    .EN(a_en), .UP(a_up), .Q(a_q), .TC(a_tc), .CO(a_co)
  );

  sync_counter_n #(.WIDTH(4), .MODULO(10), .RESET_VALUE(0)) dut_b (
    .CLK(clk), .RST(b_rst), .CLR(b_clr), .LOAD(b_load), .D(b_d),
    .EN(b_en), .UP(b_up), .Q(b_q), .TC(b_tc), .CO(b_co)
  );

  sync_counter_n #(.WIDTH(4), .MODULO(16), .RESET_VALUE(0)) dut_lo (
    .CLK(clk), .RST(c_rst), .CLR(c_clr), .LOAD(c_load), .D(c_d_lo),
    .EN(c_en), .UP(c_up), .Q(c_q_lo), .TC(c_tc_lo), .CO(c_co_lo)
  );

  sync_counter_n #(.WIDTH(4), .MODULO(16), .RESET_VALUE(0)) dut_hi (
    .CLK(clk), .RST(c_rst), .CLR(c_clr), .LOAD(c_load), .D(c_d_hi),
    .EN(c_tc_lo), .UP(c_up), .Q(c_q_hi), .TC(c_tc_hi), .CO(c_co_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour of one rising edge on instance B, from the rules.
  task automatic model_b_edge();
    if (b_clr) begin
      mb_q  = 0;
      mb_co = 1'b0;
    end else if (b_load) begin
      mb_q  = (int'(b_d) < MB) ? int'(b_d) : MB - 1;
      mb_co = 1'b0;
    end else if (b_en && b_up) begin
      mb_co = ((mb_q + 1) == MB);
      mb_q  = (mb_q + 1) % MB;
    end else if (b_en) begin
      mb_co = (mb_q == 0);
      mb_q  = (mb_q + MB - 1) % MB;
    end else begin
      mb_co = 1'b0;
    end
  endtask

  function automatic logic model_b_tc();
    return b_en && (b_up ? (mb_q == MB - 1) : (mb_q == 0));
  endfunction

  task automatic b_edge();
    model_b_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (a_q !== 4'd10 || a_co !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_initial: q=%0d co=%0b, want q=10 co=0", a_q, a_co);
    end
    @(posedge clk); #1;
    a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (a_q !== 4'd11) begin
      n_errors++;
      $display("FAIL reset_first_count: q=%0d, want 11", a_q);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_q !== 4'd3) begin
      n_errors++;
      $display("FAIL reset_reach3: q=%0d, want 3", a_q);
    end
    a_en = 1'b0;
    #3 a_rst = 1'b1;
    #1;
    n_checks++;
    if (a_q !== 4'd10 || a_co !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: q=%0d co=%0b, want q=10 co=0", a_q, a_co);
    end
    a_rst = 1'b0; a_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_q !== 4'd0 || a_co !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_wrap_pulse: q=%0d co=%0b, want q=0 co=1", a_q, a_co);
    end
    #3 a_rst = 1'b1;
    #1;
    n_checks++;
    if (a_q !== 4'd10 || a_co !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_kills_co: q=%0d co=%0b, want q=10 co=0", a_q, a_co);
    end
    a_rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (a_q !== 4'd11 || a_co !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_recount: q=%0d co=%0b, want q=11 co=0", a_q, a_co);
    end
    a_en = 1'b0;
  endtask

  task automatic test_up_wrap();
    b_clr = 1'b1; b_edge(); b_clr = 1'b0;
    b_en = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 9; i++) b_edge();
    n_checks++;
    if (b_q !== 4'd9 || b_tc !== 1'b1) begin
      n_errors++;
      $display("FAIL up_at9: q=%0d tc=%0b, want q=9 tc=1", b_q, b_tc);
    end
    b_edge();
    n_checks++;
    if (b_q !== 4'd0 || b_co !== 1'b1) begin
      n_errors++;
      $display("FAIL up_wrap: q=%0d co=%0b, want q=0 co=1", b_q, b_co);
    end
    b_edge();
    n_checks++;
    if (b_q !== 4'd1 || b_co !== 1'b0) begin
      n_errors++;
      $display("FAIL up_after_wrap: q=%0d co=%0b, want q=1 co=0", b_q, b_co);
    end
    b_en = 1'b0;
  endtask

  task automatic test_down_wrap();
    b_load = 1'b1; b_d = 4'd1; b_edge(); b_load = 1'b0;
    b_en = 1'b1; b_up = 1'b0;
    b_edge();
    n_checks++;
    if (b_q !== 4'd0 || b_tc !== 1'b1) begin
      n_errors++;
      $display("FAIL down_at0: q=%0d tc=%0b, want q=0 tc=1", b_q, b_tc);
    end
    b_edge();
    n_checks++;
    if (b_q !== 4'd9 || b_co !== 1'b1) begin
      n_errors++;
      $display("FAIL down_wrap: q=%0d co=%0b, want q=9 co=1", b_q, b_co);
    end
    b_up = 1'b1;
    b_edge();
    n_checks++;
    if (b_q !== 4'd0 || b_co !== 1'b1) begin
      n_errors++;
      $display("FAIL turnaround: q=%0d co=%0b, want q=0 co=1", b_q, b_co);
    end
    b_en = 1'b0;
  endtask

  task automatic test_load_clamp();
    b_load = 1'b1; b_d = 4'd7; b_edge();
    n_checks++;
    if (b_q !== 4'd7) begin
      n_errors++;
      $display("FAIL load7: q=%0d, want 7", b_q);
    end
    b_d = 4'd13; b_edge();
    n_checks++;
    if (b_q !== 4'd9) begin
      n_errors++;
      $display("FAIL load_clamp: q=%0d, want 9", b_q);
    end
    b_en = 1'b1; b_up = 1'b1; b_d = 4'd2;
    #1;
    n_checks++;
    if (b_tc !== 1'b1) begin
      n_errors++;
      $display("FAIL load_tc: tc=%0b, want 1", b_tc);
    end
    b_edge();
    n_checks++;
    if (b_q !== 4'd2 || b_co !== 1'b0) begin
      n_errors++;
      $display("FAIL load_over_tc: q=%0d co=%0b, want q=2 co=0", b_q, b_co);
    end
    b_load = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_priority();
    b_load = 1'b1; b_d = 4'd4; b_edge();
    b_clr = 1'b1; b_en = 1'b1; b_up = 1'b1; b_d = 4'd5;
    b_edge();
    n_checks++;
    if (b_q !== 4'd0 || b_co !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_clr: q=%0d co=%0b, want q=0 co=0", b_q, b_co);
    end
    b_clr = 1'b0; b_load = 1'b0; b_up = 1'b0;
    b_edge();
    n_checks++;
    if (b_q !== 4'd9 || b_co !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_down_wrap: q=%0d co=%0b, want q=9 co=1", b_q, b_co);
    end
    b_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 32'd0) begin
        b_rst = 1'b1;
        mb_q  = 0;
        mb_co = 1'b0;
        #1;
        n_checks++;
        if (b_q !== 4'(mb_q) || b_co !== mb_co) begin
          n_errors++;
          $display("FAIL rand_rst: q=%0d co=%0b, want q=%0d co=%0b", b_q, b_co, mb_q, mb_co);
        end
        @(posedge clk); #1;
        b_rst = 1'b0;
      end else begin
        b_clr  = ($urandom_range(0, 15) == 32'd0);
        b_load = ($urandom_range(0, 7) == 32'd0);
        b_en   = ($urandom_range(0, 3) != 32'd0);
        b_up   = 1'($urandom_range(0, 1));
        b_d    = 4'($urandom_range(0, 15));
        #1;
        n_checks++;
        if (b_tc !== model_b_tc()) begin
          n_errors++;
          $display("FAIL rand_tc: tc=%0b, want %0b (iter %0d)", b_tc, model_b_tc(), i);
        end
        b_edge();
        n_checks++;
        if (b_q !== 4'(mb_q) || b_co !== mb_co) begin
          n_errors++;
          $display("FAIL rand_q_co: q=%0d co=%0b, want q=%0d co=%0b (iter %0d)", b_q, b_co, mb_q, mb_co, i);
        end
      end
    end
    b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_cascade();
    int         cnt;
    int         lo_pulses;
    int         hi_pulses;
    logic [7:0] exp8;
    c_clr = 1'b1;
    @(posedge clk); #1;
    c_clr = 1'b0; c_en = 1'b1; c_up = 1'b1;
    cnt = 0; lo_pulses = 0; hi_pulses = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      cnt  = (cnt + 1) % 256;
      exp8 = 8'(cnt);
      if (c_co_lo === 1'b1) lo_pulses++;
      if (c_co_hi === 1'b1) hi_pulses++;
      n_checks++;
      if ({c_q_hi, c_q_lo} !== exp8) begin
        n_errors++;
        $display("FAIL casc_count: got %02h, want %02h", {c_q_hi, c_q_lo}, exp8);
      end
    end
    n_checks++;
    if ({c_q_hi, c_q_lo} !== 8'hFF || lo_pulses != 15 || hi_pulses != 0 || c_tc_lo !== 1'b1 || c_tc_hi !== 1'b1) begin
      n_errors++;
      $display("FAIL casc_ff: val=%02h lo_co=%0d hi_co=%0d tc=%0b%0b, want FF 15 0 tc=11",
               {c_q_hi, c_q_lo}, lo_pulses, hi_pulses, c_tc_hi, c_tc_lo);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({c_q_hi, c_q_lo} !== 8'h00 || c_co_lo !== 1'b1 || c_co_hi !== 1'b1) begin
      n_errors++;
      $display("FAIL casc_wrap: val=%02h co_hi=%0b co_lo=%0b, want 00 1 1", {c_q_hi, c_q_lo}, c_co_hi, c_co_lo);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({c_q_hi, c_q_lo} !== 8'h01 || c_co_lo !== 1'b0 || c_co_hi !== 1'b0) begin
      n_errors++;
      $display("FAIL casc_after: val=%02h co_hi=%0b co_lo=%0b, want 01 0 0", {c_q_hi, c_q_lo}, c_co_hi, c_co_lo);
    end
    c_up = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({c_q_hi, c_q_lo} !== 8'h00 || c_tc_lo !== 1'b1 || c_tc_hi !== 1'b1) begin
      n_errors++;
      $display("FAIL casc_down_tc: val=%02h tc=%0b%0b, want 00 tc=11", {c_q_hi, c_q_lo}, c_tc_hi, c_tc_lo);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({c_q_hi, c_q_lo} !== 8'hFF || c_co_lo !== 1'b1 || c_co_hi !== 1'b1) begin
      n_errors++;
      $display("FAIL casc_down_wrap: val=%02h co_hi=%0b co_lo=%0b, want FF 1 1", {c_q_hi, c_q_lo}, c_co_hi, c_co_lo);
    end
    c_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mb_q  = 0;
    mb_co = 1'b0;
    a_rst = 1'b1; a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0; a_up = 1'b1; a_d = 4'd0;
    b_rst = 1'b1; b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0; b_up = 1'b1; b_d = 4'd0;
    c_rst = 1'b1; c_clr = 1'b0; c_load = 1'b0; c_en = 1'b0; c_up = 1'b1;
    c_d_lo = 4'd0; c_d_hi = 4'd0;
    #12;
    b_rst = 1'b0;
    c_rst = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_priority();
    test_random();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
